// File: rtl/serial_comp_pkg.sv
// Shared types and helpers for the serial two's-complement negation unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package serial_comp_pkg;

  localparam int SC_WIDTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } sc_state_e;

  // True when the low w bits of word are 1 followed by w-1 zeros, i.e. the
  // one value whose negation does not fit in w bits. Callers zero-extend.
  function automatic logic is_min_neg(input logic [63:0] word, input int w);
    logic [63:0] msb;
    logic [63:0] low;
    msb = 64'd1 << (w - 1);
    low = msb - 64'd1;
    return ((word & msb) != 64'd0) && ((word & low) == 64'd0);
  endfunction

endpackage

// File: rtl/serial_comp_dp.sv
// Bit-serial negation datapath: right-shift register, carry flop, half adder on ~LSB.
// Latency: one bit per shift_en cycle; WIDTH cycles for a full word.
// Backpressure: none; holds whenever load and shift_en are both low.
module serial_comp_dp
  import serial_comp_pkg::*;
#(
  parameter int WIDTH = SC_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] load_data,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] sr_q;
  logic             carry_q;
  logic             inv_bit;
  logic             sum_bit;

  // Invert-and-increment one bit at a time: the carry starts at 1 (the "+1").
  assign inv_bit = ~sr_q[0];
  assign sum_bit = inv_bit ^ carry_q;

  // Shift register and carry: load presets carry, shift feeds the sum in at the MSB.
  always_ff @(posedge clk) begin
    if (reset) begin
      sr_q    <= '0;
      carry_q <= 1'b0;
    end else if (load) begin
      sr_q    <= load_data;
      carry_q <= 1'b1;
    end else if (shift_en) begin
      sr_q    <= {sum_bit, sr_q[WIDTH-1:1]};
      carry_q <= inv_bit & carry_q;
    end
  end

  assign q = sr_q;

endmodule

// File: rtl/serial_comp_ctrl.sv
// Sequencer for the serial negation datapath: accept operand, WIDTH shifts, present result.
// Latency: WIDTH+1 edges from accept edge to out_valid; one operand per WIDTH+2 cycles.
// Backpressure: result held stable in DONE until out_ready; in_ready low outside IDLE.
module serial_comp_ctrl
  import serial_comp_pkg::*;
#(
  parameter int WIDTH = SC_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_ovf,
  output logic             busy
);

  localparam int              CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  sc_state_e        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ovf_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             busy_q;

  logic             dp_load;
  logic             dp_shift_en;
  logic [WIDTH-1:0] dp_q;

  // in_ready_q is high exactly in IDLE, so this is the accept handshake.
  assign dp_load     = in_valid & in_ready_q;
  assign dp_shift_en = (state_q == SHIFT);

  // Controller FSM with registered handshake/status outputs; counter idles at 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (dp_load) begin
            state_q    <= SHIFT;
            cnt_q      <= '0;
            ovf_q      <= is_min_neg(64'(in_data), WIDTH);
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        SHIFT: begin
          if (cnt_q == CNT_LAST) begin
            state_q     <= DONE;
            cnt_q       <= '0;
            out_valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          cnt_q       <= '0;
          ovf_q       <= 1'b0;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  serial_comp_dp #(
    .WIDTH(WIDTH)
  ) u_dp (
    .clk      (clk),
    .reset    (reset),
    .load     (dp_load),
    .shift_en (dp_shift_en),
    .load_data(in_data),
    .q        (dp_q)
  );

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = dp_q;
  assign out_ovf   = ovf_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_serial_comp_ctrl.sv
// Directed bench for serial_comp_ctrl at WIDTH=4 with hand-computed results.
// Latency: checks WIDTH+1 edges accept-to-valid and WIDTH+2 accept spacing.
// Backpressure: exercises out_ready held low in DONE and in_valid held during SHIFT/DONE.
module tb_serial_comp_ctrl;

  localparam int W = 4;

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_ovf;
  logic         busy;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  serial_comp_ctrl #(
    .WIDTH(W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_ovf  (out_ovf),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One operation: accept d, wait for the result, hold out_ready low for
  // `hold` DONE cycles, then complete the output handshake.
  task automatic do_op(input logic [W-1:0] d, input logic [W-1:0] exp_d,
                       input logic exp_ovf, input int hold);
    int n;
    int nbusy;
    @(negedge clk);
    check("idle_in_ready", {31'd0, in_ready}, 32'd1);
    in_valid  = 1'b1;
    in_data   = d;
    out_ready = (hold == 0);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = ~d;
    n        = 1;
    nbusy    = 0;
    while (!out_valid && n < 20) begin
      if (busy) nbusy++;
      @(negedge clk);
      n++;
    end
    check("latency", n, W + 1);
    check("out_data", {28'd0, out_data}, {28'd0, exp_d});
    check("out_ovf", {31'd0, out_ovf}, {31'd0, exp_ovf});
    check("done_in_ready", {31'd0, in_ready}, 32'd0);
    for (int h = 0; h < hold; h++) begin
      if (busy) nbusy++;
      check("hold_valid", {31'd0, out_valid}, 32'd1);
      check("hold_data", {28'd0, out_data}, {28'd0, exp_d});
      check("hold_in_ready", {31'd0, in_ready}, 32'd0);
      @(negedge clk);
    end
    if (busy) nbusy++;
    out_ready = 1'b1;
    @(negedge clk);
    check("post_in_ready", {31'd0, in_ready}, 32'd1);
    check("post_out_valid", {31'd0, out_valid}, 32'd0);
    check("post_busy", {31'd0, busy}, 32'd0);
    check("busy_cycles", nbusy, W + 1 + hold);
  endtask

  logic [W-1:0] ops [2];
  logic [W-1:0] exps[2];
  int           acc_cyc[2];
  int           n_acc;
  int           n_out;
  int           seen_valid;

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;

    // Reset state, sampled while reset is still asserted after an edge.
    @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", {28'd0, out_data}, 32'd0);
    check("rst_out_ovf", {31'd0, out_ovf}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;

    // Directed vectors: -x mod 16.
    do_op(4'b0101, 4'b1011, 1'b0, 0);
    do_op(4'b0000, 4'b0000, 1'b0, 0);
    do_op(4'b1111, 4'b0001, 1'b0, 0);
    do_op(4'b1000, 4'b1000, 1'b1, 0);
    do_op(4'b0111, 4'b1001, 1'b0, 0);
    do_op(4'b0011, 4'b1101, 1'b0, 7);

    // Reset at the second shift edge aborts the operation.
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 4'b0110;
    @(negedge clk);            // accept edge passed
    in_valid = 1'b0;
    @(negedge clk);            // first shift edge passed
    reset = 1'b1;
    @(negedge clk);            // second shift edge, reset sampled
    reset = 1'b0;
    check("abort_in_ready", {31'd0, in_ready}, 32'd1);
    check("abort_out_valid", {31'd0, out_valid}, 32'd0);
    check("abort_out_data", {28'd0, out_data}, 32'd0);
    check("abort_out_ovf", {31'd0, out_ovf}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    seen_valid = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) seen_valid++;
    end
    check("abort_no_result", seen_valid, 0);
    do_op(4'b0001, 4'b1111, 1'b0, 0);

    // in_valid held high with changing data; only IDLE-accepted operands count.
    ops[0]  = 4'b0010;
    ops[1]  = 4'b0111;
    exps[0] = 4'b1110;
    exps[1] = 4'b1001;
    n_acc   = 0;
    n_out   = 0;
    for (int i = 0; i < 40 && n_out < 2; i++) begin
      @(negedge clk);
      if (out_valid) begin
        check("b2b_out_data", {28'd0, out_data}, {28'd0, exps[n_out]});
        n_out++;
      end
      if (in_ready && n_acc < 2) begin
        in_valid       = 1'b1;
        in_data        = ops[n_acc];
        acc_cyc[n_acc] = cyc;
        n_acc++;
      end else begin
        in_valid = (n_acc < 2) || !in_ready;
        in_data  = W'($urandom);
      end
    end
    in_valid = 1'b0;
    check("b2b_results", n_out, 2);
    check("b2b_accepts", n_acc, 2);
    if (n_acc == 2) check("b2b_spacing", acc_cyc[1] - acc_cyc[0], W + 2);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
